dm_responder: RTL

- Data-side responder for the pipelined RV32 core: a word-addressed data RAM plus a memory-mapped countdown timer that drives the core's INT input.
- Serves the core's MEM-stage bus: address, write data, DMType, mem_w.
- Reads are combinational and return within the same cycle, so the MEM/WB register captures them. Writes commit on the clock edge.

---
 rtl/dm_pkg.sv | 78 +++++++
 rtl/dm_timer.sv | 117 +++++++++++
 rtl/dm_responder.sv | 67 ++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-side responder: access types, timer
// register map, CTRL bits, timer FSM states and lane-steering helpers.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    // Word index within the 16-byte timer block (byte offset >> 2)
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_MODE = 2;
    localparam int STAT_PEND = 0;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tstate_e;

    function automatic logic [3:0] lane_be(
        input logic [2:0] t,
        input logic [1:0] a
    );
        logic [3:0] be;
        be = 4'b0000;
        case (t)
            DM_WORD:            be = 4'b1111;
            DM_HALF, DM_HALF_U: be = a[1] ? 4'b1100 : 4'b0011;
            DM_BYTE, DM_BYTE_U: be = 4'b0001 << a;
            default:            be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(
        input logic [2:0]  t,
        input logic [31:0] d
    );
        logic [31:0] w;
        case (t)
            DM_HALF, DM_HALF_U: w = {2{d[15:0]}};
            DM_BYTE, DM_BYTE_U: w = {4{d[7:0]}};
            default:            w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] lane_rdata(
        input logic [2:0]  t,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [15:0] h;
        logic [31:0] s;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? w[31:16] : w[15:0];
        s = w >> {a, 3'b000};
        b = s[7:0];
        case (t)
            DM_WORD:   r = w;
            DM_HALF:   r = {{16{h[15]}}, h};
            DM_HALF_U: r = {16'h0000, h};
            DM_BYTE:   r = {{24{b[7]}}, b};
            DM_BYTE_U: r = {24'h00_0000, b};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_timer.sv
// Memory-mapped countdown timer with sticky PEND and one-cycle INT pulse.
// Periodic auto-reload (CTRL.MODE) exists only when TIMER_RELOAD_EN is defined.
module dm_timer
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [1:0]  reg_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        int_o
);

    tstate_e     state_q;
    logic        en_q;
    logic        ie_q;
    logic        pend_q;
    logic        int_q;
    logic [31:0] reload_q;
    logic [31:0] count_q;
    logic        mode_rd;
`ifdef TIMER_RELOAD_EN
    logic        mode_q;
`endif

    logic ctrl_wr;
    logic reload_wr;
    logic status_wr;

    assign ctrl_wr   = we_i && (reg_i == REG_CTRL);
    assign reload_wr = we_i && (reg_i == REG_RELOAD);
    assign status_wr = we_i && (reg_i == REG_STATUS);

`ifdef TIMER_RELOAD_EN
    assign mode_rd = mode_q;
`else
    assign mode_rd = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= T_IDLE;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            pend_q   <= 1'b0;
            int_q    <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
`ifdef TIMER_RELOAD_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            int_q <= 1'b0;
            if (ctrl_wr) begin
                en_q <= wdata_i[CTRL_EN];
                ie_q <= wdata_i[CTRL_IE];
`ifdef TIMER_RELOAD_EN
                mode_q <= wdata_i[CTRL_MODE];
`endif
            end
            if (reload_wr) begin
                reload_q <= wdata_i;
            end
            // A fire on this edge re-sets PEND below, so set beats clear
            if (status_wr && wdata_i[STAT_PEND]) begin
                pend_q <= 1'b0;
            end
            unique case (state_q)
                T_IDLE: begin
                    if (ctrl_wr && wdata_i[CTRL_EN]) begin
                        state_q <= T_RUN;
                        count_q <= reload_q;
                    end
                end
                T_RUN: begin
                    if (ctrl_wr && !wdata_i[CTRL_EN]) begin
                        state_q <= T_IDLE;
                    end else if (count_q <= 32'd1) begin
                        pend_q <= 1'b1;
                        int_q  <= ie_q;
`ifdef TIMER_RELOAD_EN
                        if (mode_q) begin
                            count_q <= reload_q;
                        end else begin
                            count_q <= '0;
                            en_q    <= 1'b0;
                            state_q <= T_IDLE;
                        end
`else
                        count_q <= '0;
                        en_q    <= 1'b0;
                        state_q <= T_IDLE;
`endif
                    end else begin
                        count_q <= count_q - 32'd1;
                    end
                end
                default: state_q <= T_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_CTRL:   rdata_o = {29'd0, mode_rd, ie_q, en_q};
            REG_RELOAD: rdata_o = reload_q;
            REG_COUNT:  rdata_o = count_q;
            REG_STATUS: rdata_o = {31'd0, pend_q};
            default:    rdata_o = '0;
        endcase
    end

    assign int_o = int_q;

endmodule

// File: rtl/dm_responder.sv
// Data-side responder: word RAM with lane steering plus the MMIO timer.
// Build with TIMER_RELOAD_EN to enable periodic auto-reload in the timer.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        INT
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic          mmio_sel;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   t_rdata;
    logic [31:0]   word;
    logic          t_we;

    assign mmio_sel = (Addr_in[31:4] == MMIO_BASE[31:4]);
    assign idx      = Addr_in[AW+1:2];
    assign be       = lane_be(DMType, Addr_in[1:0]);
    assign wlanes   = lane_wdata(DMType, Data_in);

    // Timer registers only accept full-word stores
    assign t_we = mem_w && mmio_sel && (DMType == DM_WORD);

    always_ff @(posedge clk) begin
        if (!reset && mem_w && !mmio_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    dm_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .we_i    (t_we),
        .reg_i   (Addr_in[3:2]),
        .wdata_i (Data_in),
        .rdata_o (t_rdata),
        .int_o   (INT)
    );

    assign word = mmio_sel ? t_rdata : mem_q[idx];

    always_comb begin
        Data_out = '0;
        if (!reset && !mem_w) begin
            Data_out = lane_rdata(DMType, Addr_in[1:0], word);
        end
    end

endmodule
